fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the EX-stage forwarding unit.
- Keeps its own shadow pipeline of destination tags, covering the instruction in EX plus FWD_DEPTH downstream stages.
- Produces forward-select codes for NUM_SRC EX operands and a load-use stall for the ID instruction.
- Sits beside the ID/EX register. Drives the EX operand muxes and the IF/ID freeze / EX bubble-insert logic.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (rs1, rs2, ...).
- FWD_DEPTH, 3, number of post-EX stages that can forward (stage 1 = EX/MEM ... stage FWD_DEPTH).
- LOAD_STAGE, 2, first stage index at which load data is forwardable. Range 1..FWD_DEPTH.
- REG_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- adv_i  in  1  pipeline advances this cycle (0 = global freeze, e.g. cache miss)
- flush_i  in  1  squash the instruction entering EX; sampled only when adv_i=1
- id_valid_i  in  1  ID holds a valid instruction
- id_rd_i  in  REG_W  ID destination register
- id_we_i  in  1  ID instruction writes the regfile
- id_is_load_i  in  1  ID instruction is a load
- id_rs_i  in  NUM_SRC*REG_W  ID sources, packed; operand j at [j*REG_W +: REG_W]
- ex_rs_i  in  NUM_SRC*REG_W  EX sources, packed the same way
- fwd_sel_o  out  NUM_SRC*SW  per-operand select; SW=$clog2(FWD_DEPTH+1); 0 = regfile, k = stage k
- load_use_stall_o  out  1  freeze PC and IF/ID, insert bubble into EX

Behaviour:
- Tag entry: {valid, we, is_load, rd}. Array tag[0..FWD_DEPTH]; tag[0] is the instruction in EX.
- Reset: all tags cleared (valid=0). fwd_sel_o=0, load_use_stall_o=0, immediately and asynchronously.
- adv_i=0: all tags hold. Outputs are recomputed from the held state.
- adv_i=1: tag[k] <= tag[k-1] for k=1..FWD_DEPTH. The tag in the last stage retires.
- tag[0] on adv_i=1:
  - becomes a bubble if flush_i, load_use_stall_o or !id_valid_i;
  - otherwise captures {1, id_we_i, id_is_load_i, id_rd_i}.
- Live entry (stage k): valid && we && rd!=0.
- fwd_sel[j] (combinational from registered tags, zero latency):
  - equals the smallest k in 1..FWD_DEPTH where tag[k] is live and tag[k].rd == ex_rs[j];
  - 0 if no such k.
  - Youngest producer wins. rs=x0 never forwards.
- load_use_stall_o (combinational):
  - asserted when id_valid_i and some k in 0..LOAD_STAGE-2 has a live load tag[k] whose rd matches any id_rs[j];
  - LOAD_STAGE=1 means never stall.
  - Asserted independently of adv_i. It takes effect only on an advancing edge.
- A load tag at stage k<LOAD_STAGE can still be reported by fwd_sel. Correctness is guaranteed by the stall: no legal sequence reaches EX with such a dependency.
- Simultaneous events:
  - flush_i and load_use_stall_o together give a single bubble.
  - id_we_i=1 with id_rd_i=0 is captured but is never live.
- Reset mid-operation discards all in-flight tags. The first post-reset cycle reports no forwards.
- Non-power-of-two FWD_DEPTH is legal. Unused fwd_sel codes are never driven.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- Defined: adds output ports perf_stall_cnt_o (32) and perf_fwd_cnt_o (32). Both are cleared by rst.
  - perf_stall_cnt_o increments on each adv_i=1 cycle with load_use_stall_o=1.
  - perf_fwd_cnt_o increments by the number of operands with nonzero fwd_sel on each adv_i=1 cycle.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports absent, no counter logic.

Test Plan:
- Back-to-back ALU: "add x5" enters EX, next cycle ex_rs1=5 -> fwd_sel[0]=1. Two cycles later (one intervening instruction) -> fwd_sel[0]=2.
- Multiple producers: x7 written at stages 1 and 3, ex_rs2=7 -> fwd_sel[1]=1 (youngest). Default params.
- Load-use:
  - "lw x9" in EX, ID rs1=9 -> load_use_stall_o=1; next edge tag[0] is a bubble, stall drops.
  - Then ex_rs1=9 -> fwd_sel[0]=2.
- Freeze: adv_i=0 for 5 cycles with "add x3" at stage 1 -> fwd_sel stays 1 for all 5 cycles; tags unchanged after release.
- x0 and flush:
  - producer rd=0, ex_rs=0 -> fwd_sel=0;
  - flush_i with "add x4" in ID -> it never forwards (fwd_sel=0 on following cycles).
- Async reset asserted mid-stream with 3 live tags -> outputs 0 in the same cycle. With FWD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
//   Operand-forwarding and load-use hazard unit that sits beside the ID/EX
//   register. It keeps a shadow pipeline of destination tags for the
//   instruction in EX (stage 0) and FWD_DEPTH downstream stages. From those
//   tags it produces:
//     - a forward-select code for each EX source operand
//       (0 = regfile, k = value from stage k, youngest producer wins);
//     - a load-use stall for the instruction currently in ID.
//
// Ports
//   clk               clock
//   rst               asynchronous active-high reset, clears all tags
//   adv_i             pipeline advances this cycle (0 = global freeze)
//   flush_i           squash the instruction entering EX (used when adv_i=1)
//   id_valid_i        ID holds a valid instruction
//   id_rd_i           ID destination register
//   id_we_i           ID instruction writes the regfile
//   id_is_load_i      ID instruction is a load
//   id_rs_i           ID sources, operand j at [j*REG_W +: REG_W]
//   ex_rs_i           EX sources, same packing
//   fwd_sel_o         per-operand select, operand j at [j*SW +: SW]
//   load_use_stall_o  freeze PC and IF/ID, insert bubble into EX
//
// Optional build macro FWD_PERF_CNT_EN adds two saturating 32-bit counters:
//   perf_stall_cnt_o  advancing cycles on which a load-use stall was applied
//   perf_fwd_cnt_o    sum of forwarded operands over advancing cycles
module fwd_hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_STAGE = 2,
  parameter int REG_W      = 5,
  localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv_i,
  input  logic                     flush_i,
  input  logic                     id_valid_i,
  input  logic [REG_W-1:0]         id_rd_i,
  input  logic                     id_we_i,
  input  logic                     id_is_load_i,
  input  logic [NUM_SRC*REG_W-1:0] id_rs_i,
  input  logic [NUM_SRC*REG_W-1:0] ex_rs_i,
  output logic [NUM_SRC*SW-1:0]    fwd_sel_o,
  output logic                     load_use_stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_fwd_cnt_o
`endif
);

  // Tag fields, index 0 = instruction in EX, index k = k stages past EX.
  logic [FWD_DEPTH:0] tag_vld_q, tag_vld_d;
  logic [FWD_DEPTH:0] tag_we_q,  tag_we_d;
  logic [FWD_DEPTH:0] tag_ld_q,  tag_ld_d;
  logic [REG_W-1:0]   tag_rd_q [FWD_DEPTH+1];
  logic [REG_W-1:0]   tag_rd_d [FWD_DEPTH+1];

  logic [FWD_DEPTH:0] live;
  logic               stall;

  // The is_load flag is carried through every stage to keep the tag whole,
  // but only stages below LOAD_STAGE-1 feed the stall decision.
  logic unused_ld;
  assign unused_ld = ^tag_ld_q;

  // A stage can only forward if it really writes a nonzero register.
  always_comb begin
    live = '0;
    for (int k = 0; k <= FWD_DEPTH; k++) begin
      live[k] = tag_vld_q[k] && tag_we_q[k] && (tag_rd_q[k] != '0);
    end
  end

  // Scan oldest to youngest so the smallest matching stage index wins.
  // A live tag never has rd=0, so ex_rs=x0 can never match.
  always_comb begin
    fwd_sel_o = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (live[k] && (tag_rd_q[k] == ex_rs_i[j*REG_W +: REG_W])) begin
          fwd_sel_o[j*SW +: SW] = SW'(k);
        end
      end
    end
  end

  // A load at stage k < LOAD_STAGE-1 cannot have its data ready by the time
  // the dependent ID instruction reaches EX; with LOAD_STAGE=1 the loop is
  // empty and no stall is ever raised.
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < LOAD_STAGE - 1; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (live[k] && tag_ld_q[k] &&
            (tag_rd_q[k] == id_rs_i[j*REG_W +: REG_W])) begin
          stall = 1'b1;
        end
      end
    end
    stall = stall && id_valid_i;
  end

  assign load_use_stall_o = stall;

  // Shift on advance; a stall, flush or empty ID slot inserts one bubble.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_we_d  = tag_we_q;
    tag_ld_d  = tag_ld_q;
    tag_rd_d  = tag_rd_q;
    if (adv_i) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        tag_vld_d[k] = tag_vld_q[k-1];
        tag_we_d[k]  = tag_we_q[k-1];
        tag_ld_d[k]  = tag_ld_q[k-1];
        tag_rd_d[k]  = tag_rd_q[k-1];
      end
      if (flush_i || stall || !id_valid_i) begin
        tag_vld_d[0] = 1'b0;
        tag_we_d[0]  = 1'b0;
        tag_ld_d[0]  = 1'b0;
        tag_rd_d[0]  = '0;
      end else begin
        tag_vld_d[0] = 1'b1;
        tag_we_d[0]  = id_we_i;
        tag_ld_d[0]  = id_is_load_i;
        tag_rd_d[0]  = id_rd_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_we_q  <= '0;
      tag_ld_q  <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        tag_rd_q[k] <= '0;
      end
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_we_q  <= tag_we_d;
      tag_ld_q  <= tag_ld_d;
      tag_rd_q  <= tag_rd_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_fwd_cnt_q,   perf_fwd_cnt_d;
  logic [31:0] fwd_nz;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    fwd_nz = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (fwd_sel_o[j*SW +: SW] != '0) begin
        fwd_nz = fwd_nz + 32'd1;
      end
    end
  end

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_fwd_cnt_d   = perf_fwd_cnt_q;
    if (adv_i) begin
      if (stall) begin
        perf_stall_cnt_d = sat_add(perf_stall_cnt_q, 32'd1);
      end
      perf_fwd_cnt_d = sat_add(perf_fwd_cnt_q, fwd_nz);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_fwd_cnt_q   <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_fwd_cnt_q   <= perf_fwd_cnt_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_q;
  assign perf_fwd_cnt_o   = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
module tb_fwd_hazard_scoreboard;

  localparam int NUM_SRC    = 2;
  localparam int FWD_DEPTH  = 3;
  localparam int LOAD_STAGE = 2;
  localparam int REG_W      = 5;
  localparam int SW         = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     adv_i;
  logic                     flush_i;
  logic                     id_valid_i;
  logic [REG_W-1:0]         id_rd_i;
  logic                     id_we_i;
  logic                     id_is_load_i;
  logic [NUM_SRC*REG_W-1:0] id_rs_i;
  logic [NUM_SRC*REG_W-1:0] ex_rs_i;
  logic [NUM_SRC*SW-1:0]    fwd_sel_o;
  logic                     load_use_stall_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(
    .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH),
    .LOAD_STAGE(LOAD_STAGE), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst), .adv_i(adv_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rd_i(id_rd_i), .id_we_i(id_we_i),
    .id_is_load_i(id_is_load_i), .id_rs_i(id_rs_i), .ex_rs_i(ex_rs_i),
    .fwd_sel_o(fwd_sel_o), .load_use_stall_o(load_use_stall_o)
  );

  // Reference model: a queue of in-flight instructions, front = EX.
  typedef struct packed {
    bit       v;
    bit       we;
    bit       ld;
    bit [4:0] rd;
  } tag_t;

  tag_t mq[$];
  tag_t nt_m;

  function automatic bit m_stall();
    if (id_valid_i !== 1'b1) return 1'b0;
    for (int k = 0; k < LOAD_STAGE - 1; k++)
      for (int j = 0; j < NUM_SRC; j++)
        if (mq[k].v && mq[k].we && mq[k].ld && mq[k].rd != 0 &&
            mq[k].rd == id_rs_i[j*REG_W +: REG_W])
          return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fwd(input logic [4:0] rs);
    for (int k = 1; k <= FWD_DEPTH; k++)
      if (mq[k].v && mq[k].we && mq[k].rd != 0 && mq[k].rd == rs)
        return k;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      repeat (FWD_DEPTH + 1) mq.push_back('0);
    end else if (adv_i === 1'b1) begin
      if (flush_i || m_stall() || !id_valid_i) nt_m = '0;
      else nt_m = {1'b1, id_we_i, id_is_load_i, id_rd_i};
      void'(mq.pop_back());
      mq.push_front(nt_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid_i = 0; id_we_i = 0; id_is_load_i = 0; id_rd_i = 0; id_rs_i = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    id_valid_i = 1; id_rd_i = rd; id_we_i = we; id_is_load_i = ld;
    id_rs_i = {rs1, rs0};
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    adv_i = 1; flush_i = 0; ex_rs_i = 0;
    idle_id();
    tick();
  endtask

  task automatic test_reset();
    adv_i = 1; flush_i = 0;
    issue(5'd9, 1, 1, 5'd9, 5'd9);
    ex_rs_i = {5'd1, 5'd2};
    rst = 1;
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0 || load_use_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold fwd=%0h stall=%0b want fwd=0 stall=0", fwd_sel_o, load_use_stall_o);
    end
    tick(); tick();
    rst = 0;
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_cycle fwd=%0h want 0", fwd_sel_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd5, 1, 0, 5'd1, 5'd2);
    tick();
    idle_id();
    ex_rs_i = {5'd0, 5'd5};
    tick();
    #1;
    checks++;
    if (fwd_sel_o[1:0] !== 2'd1) begin
      errors++; $display("FAIL b2b_stage1 got %0d want 1", fwd_sel_o[1:0]);
    end
    tick();
    #1;
    checks++;
    if (fwd_sel_o[1:0] !== 2'd2) begin
      errors++; $display("FAIL b2b_stage2 got %0d want 2", fwd_sel_o[1:0]);
    end
    tick();
    #1;
    checks++;
    if (fwd_sel_o[1:0] !== 2'd3) begin
      errors++; $display("FAIL b2b_stage3 got %0d want 3", fwd_sel_o[1:0]);
    end
    tick();
    #1;
    checks++;
    if (fwd_sel_o[1:0] !== 2'd0) begin
      errors++; $display("FAIL b2b_retired got %0d want 0", fwd_sel_o[1:0]);
    end
  endtask

  task automatic test_multi_producer();
    do_reset();
    issue(5'd7, 1, 0, 5'd0, 5'd0); tick();
    issue(5'd8, 1, 0, 5'd0, 5'd0); tick();
    issue(5'd7, 1, 0, 5'd0, 5'd0); tick();
    idle_id(); tick();
    ex_rs_i = {5'd7, 5'd8};
    #1;
    checks++;
    if (fwd_sel_o !== {2'd1, 2'd2}) begin
      errors++;
      $display("FAIL multi_producer got rs1=%0d rs2=%0d want rs1=2 rs2=1", fwd_sel_o[1:0], fwd_sel_o[3:2]);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd9, 1, 1, 5'd0, 5'd0); tick();
    issue(5'd10, 1, 0, 5'd9, 5'd0);
    #1;
    checks++;
    if (load_use_stall_o !== 1'b1) begin
      errors++; $display("FAIL load_use_assert got %0b want 1", load_use_stall_o);
    end
    tick();
    #1;
    checks++;
    if (load_use_stall_o !== 1'b0) begin
      errors++; $display("FAIL load_use_release got %0b want 0", load_use_stall_o);
    end
    tick();
    idle_id();
    ex_rs_i = {5'd0, 5'd9};
    #1;
    checks++;
    if (fwd_sel_o[1:0] !== 2'd2) begin
      errors++; $display("FAIL load_use_fwd got %0d want 2", fwd_sel_o[1:0]);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    issue(5'd3, 1, 0, 5'd0, 5'd0); tick();
    idle_id(); tick();
    ex_rs_i = {5'd6, 5'd3};
    adv_i = 0;
    issue(5'd6, 1, 0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (fwd_sel_o !== {2'd0, 2'd1}) begin
        errors++;
        $display("FAIL freeze_cycle%0d got rs1=%0d rs2=%0d want 1 0", i, fwd_sel_o[1:0], fwd_sel_o[3:2]);
      end
      tick();
    end
    idle_id();
    adv_i = 1;
    tick();
    #1;
    checks++;
    if (fwd_sel_o !== {2'd0, 2'd2}) begin
      errors++;
      $display("FAIL freeze_release got rs1=%0d rs2=%0d want 2 0", fwd_sel_o[1:0], fwd_sel_o[3:2]);
    end
  endtask

  task automatic test_x0_flush();
    do_reset();
    issue(5'd0, 1, 0, 5'd0, 5'd0); tick();
    idle_id(); tick();
    ex_rs_i = 0;
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++; $display("FAIL x0_never_fwd got %0h want 0", fwd_sel_o);
    end
    issue(5'd4, 1, 0, 5'd0, 5'd0);
    flush_i = 1;
    tick();
    flush_i = 0;
    idle_id();
    tick();
    ex_rs_i = {5'd4, 5'd4};
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++; $display("FAIL flush_stage1 got %0h want 0", fwd_sel_o);
    end
    tick();
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++; $display("FAIL flush_stage2 got %0h want 0", fwd_sel_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(5'd11, 1, 0, 5'd0, 5'd0); tick();
    issue(5'd12, 1, 0, 5'd0, 5'd0); tick();
    issue(5'd13, 1, 0, 5'd0, 5'd0); tick();
    issue(5'd14, 1, 1, 5'd0, 5'd0); tick();
    issue(5'd15, 1, 0, 5'd14, 5'd0);
    ex_rs_i = {5'd11, 5'd12};
    #1;
    checks++;
    if (fwd_sel_o !== {2'd3, 2'd2} || load_use_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset fwd=%0h stall=%0b want fwd=e stall=1", fwd_sel_o, load_use_stall_o);
    end
    rst = 1;
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0 || load_use_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset fwd=%0h stall=%0b want fwd=0 stall=0", fwd_sel_o, load_use_stall_o);
    end
    #1;
    rst = 0;
    idle_id();
    tick();
    #1;
    checks++;
    if (fwd_sel_o !== 4'd0) begin
      errors++; $display("FAIL post_reset_cycle got %0h want 0", fwd_sel_o);
    end
  endtask

  task automatic test_random();
    logic [1:0] e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      adv_i        = ($urandom % 10) != 0;
      flush_i      = ($urandom % 10) == 0;
      id_valid_i   = ($urandom % 4) != 0;
      id_rd_i      = 5'($urandom % 8);
      id_we_i      = ($urandom % 4) != 0;
      id_is_load_i = ($urandom % 3) == 0;
      id_rs_i      = {5'($urandom % 8), 5'($urandom % 8)};
      ex_rs_i      = {5'($urandom % 8), 5'($urandom % 8)};
      #1;
      for (int j = 0; j < NUM_SRC; j++) begin
        e = 2'(m_fwd(ex_rs_i[j*REG_W +: REG_W]));
        checks++;
        if (fwd_sel_o[j*SW +: SW] !== e) begin
          errors++;
          $display("FAIL rand_fwd n=%0d op=%0d got %0d want %0d", n, j, fwd_sel_o[j*SW +: SW], e);
        end
      end
      checks++;
      if (load_use_stall_o !== m_stall()) begin
        errors++;
        $display("FAIL rand_stall n=%0d got %0b want %0b", n, load_use_stall_o, m_stall());
      end
      tick();
    end
  endtask

  initial begin
    adv_i = 1; flush_i = 0; ex_rs_i = 0;
    idle_id();
    #1;
    test_reset();
    test_back_to_back();
    test_multi_producer();
    test_load_use();
    test_freeze();
    test_x0_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
